// File: rtl/aud_pkg.sv
// aud_pkg: shared opcodes, size codes, status bytes and sequencer states for the AUD host sequencer
package aud_pkg;
  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_RD = 2'b10;
  localparam logic [1:0] SZ_B0 = 2'd0;
  localparam logic [1:0] SZ_B1 = 2'd1;
  localparam logic [1:0] SZ_H  = 2'd2;
  localparam logic [1:0] SZ_W  = 2'd3;
  localparam logic [7:0] ST_OK    = 8'hA0;
  localparam logic [7:0] ST_AUD   = 8'hA2;
  localparam logic [7:0] ST_TO    = 8'hA4;
  localparam logic [7:0] ST_BADOP = 8'hE1;
  typedef enum logic [3:0] {
    S_GET_OP, S_GET_ADDR, S_GET_CNT, S_GET_DATA, S_ISSUE, S_GUARD,
    S_WAIT_IDLE, S_SEND_DATA, S_NEXT, S_SEND_STATUS, S_ABORT
  } state_t;
  function automatic logic [2:0] size_bytes(input logic [1:0] s);
    return s == SZ_W ? 3'd4 : s == SZ_H ? 3'd2 : 3'd1;
  endfunction
endpackage

// File: rtl/aud_rmm_watchdog.sv
// aud_rmm_watchdog: per-element timeout counter, expires on the TIMEOUT_CYCLES-th running cycle after a clear
module aud_rmm_watchdog #(
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic run_i,
  output logic expire_o
);
  logic [TO_W-1:0] cnt;
  assign expire_o = run_i && cnt == TO_W'(TIMEOUT_CYCLES - 1);
  // count running cycles, saturating once expired
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) cnt <= '0;
    else if (run_i && !expire_o) cnt <= cnt + TO_W'(1);
  end
endmodule

// File: rtl/aud_rmm_host_seq.sv
// aud_rmm_host_seq: parses host read/write frames, strobes the RMM engine per element and returns data plus status
module aud_rmm_host_seq import aud_pkg::*; #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [31:0] rmm_addr_o,
  output logic [31:0] rmm_data_o,
  output logic [1:0]  rmm_size_o,
  output logic        rmm_we_o,
  output logic        rmm_re_o,
  input  logic [31:0] rmm_data_i,
  input  logic        rmm_err_i,
  input  logic        rmm_idle_i,
  output logic        rmm_abort_o
);
  state_t st, nst;
  logic wr, g, rx_acc, tx_acc, last, op_ok, strobe, run, expire, to_hit;
  logic [1:0] sz, idx;
  logic [31:0] addr, wdat, cap;
  logic [8:0] rem;
  logic [7:0] stat;
  assign rx_ready_o = !rst_i && st inside {S_GET_OP, S_GET_ADDR, S_GET_CNT, S_GET_DATA};
  assign tx_valid_o = st inside {S_SEND_DATA, S_SEND_STATUS};
  assign tx_data_o = st == S_SEND_DATA ? 8'(cap >> {idx, 3'b000}) : st == S_SEND_STATUS ? stat : 8'h00;
  assign rx_acc = rx_valid_i && rx_ready_o;
  assign tx_acc = tx_valid_o && tx_ready_i;
  assign last = idx == 2'(size_bytes(sz) - 3'd1);
  assign op_ok = (rx_data_i[7:6] == OP_WR || rx_data_i[7:6] == OP_RD) && rx_data_i[3:0] == 4'h0;
  assign strobe = st == S_ISSUE && rmm_idle_i;
  assign run = st inside {S_ISSUE, S_GUARD, S_WAIT_IDLE};
  assign to_hit = expire && !(st inside {S_ISSUE, S_WAIT_IDLE} && rmm_idle_i);
  assign rmm_we_o = strobe && wr;
  assign rmm_re_o = strobe && !wr;
  assign rmm_abort_o = to_hit;
  assign rmm_addr_o = addr;
  assign rmm_data_o = wdat;
  assign rmm_size_o = sz;
  aud_rmm_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(!run || strobe), .run_i(run), .expire_o(expire)
  );
  // state register; g times the two-cycle guard and post-abort waits
  always_ff @(posedge clk_i) begin
    st <= rst_i ? S_GET_OP : nst;
    g <= !rst_i && nst == st && st inside {S_GUARD, S_ABORT} ? !g : 1'b0;
  end
  // next-state logic; an idle RMM rescues a cycle that would otherwise time out
  always_comb begin
    nst = st;
    case (st)
      S_GET_OP:      nst = rx_acc ? (op_ok ? S_GET_ADDR : S_SEND_STATUS) : st;
      S_GET_ADDR:    nst = rx_acc && idx == 2'd3 ? S_GET_CNT : st;
      S_GET_CNT:     nst = rx_acc ? (wr ? S_GET_DATA : S_ISSUE) : st;
      S_GET_DATA:    nst = rx_acc && last ? S_ISSUE : st;
      S_ISSUE:       nst = to_hit ? S_ABORT : rmm_idle_i ? S_GUARD : st;
      S_GUARD:       nst = to_hit ? S_ABORT : g ? S_WAIT_IDLE : st;
      S_WAIT_IDLE:   nst = to_hit ? S_ABORT : !rmm_idle_i ? st : rmm_err_i ? S_SEND_STATUS : wr ? S_NEXT : S_SEND_DATA;
      S_SEND_DATA:   nst = tx_acc && last ? S_NEXT : st;
      S_NEXT:        nst = rem == 9'd1 ? S_SEND_STATUS : wr ? S_GET_DATA : S_ISSUE;
      S_SEND_STATUS: nst = tx_acc ? S_GET_OP : st;
      S_ABORT:       nst = g ? S_SEND_STATUS : st;
      default:       nst = S_GET_OP;
    endcase
  end
  // frame fields, element data, captured read word and status accumulation
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr <= 1'b0; sz <= SZ_B0; idx <= 2'd0; addr <= '0; wdat <= '0; cap <= '0; rem <= '0; stat <= '0;
    end else begin
      case (st)
        S_GET_OP: if (rx_acc) begin
          wr <= rx_data_i[7:6] == OP_WR; sz <= rx_data_i[5:4]; idx <= 2'd0; stat <= op_ok ? ST_OK : ST_BADOP;
        end
        S_GET_ADDR: if (rx_acc) begin
          addr <= {rx_data_i, addr[31:8]}; idx <= idx + 2'd1;
        end
        S_GET_CNT: if (rx_acc) rem <= {rx_data_i == 8'd0, rx_data_i};
        S_GET_DATA: if (rx_acc) begin
          wdat <= idx == 2'd0 ? {24'd0, rx_data_i} : wdat | (32'(rx_data_i) << {idx, 3'b000});
          idx <= last ? 2'd0 : idx + 2'd1;
        end
        S_WAIT_IDLE: if (rmm_idle_i) begin
          cap <= rmm_data_i; idx <= 2'd0; stat <= rmm_err_i ? stat | ST_AUD : stat;
        end
        S_SEND_DATA: if (tx_acc) idx <= last ? 2'd0 : idx + 2'd1;
        S_NEXT: if (rem != 9'd1) begin
          rem <= rem - 9'd1; addr <= addr + 32'(size_bytes(sz));
        end
        S_ABORT: stat <= stat | ST_TO;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_aud_rmm_host_seq.sv
// tb_aud_rmm_host_seq: directed self-checking bench with an RMM engine model and host byte streams
module tb_aud_rmm_host_seq;
  logic clk_i = 0, rst_i = 1, rx_valid_i = 0, tx_ready_i = 1;
  logic [7:0] rx_data_i = 0, tx_data_o;
  logic rx_ready_o, tx_valid_o, rmm_we_o, rmm_re_o, rmm_err_i, rmm_idle_i, rmm_abort_o;
  logic [31:0] rmm_addr_o, rmm_data_o, rmm_data_i;
  logic [1:0] rmm_size_o;
  int n_chk = 0, n_fail = 0, cyc = 0;
  logic m_idle = 1;
  int m_dly = 0, m_cur = 0, m_delay = 3, m_err_idx = -1, f_base = 0;
  bit m_hang = 0;
  logic [31:0] rd_tab [0:7];
  logic [31:0] s_addr [0:1023], s_data [0:1023];
  logic [1:0] s_size [0:1023];
  logic s_we [0:1023];
  int s_cyc [0:1023];
  int scnt = 0, viol = 0, unstable = 0, n_abort = 0, abort_cyc = 0, tcnt = 0;
  logic [7:0] tx_buf [0:1023];

  always #5 clk_i = ~clk_i;

  aud_rmm_host_seq #(.TIMEOUT_CYCLES(64)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .rmm_addr_o(rmm_addr_o), .rmm_data_o(rmm_data_o), .rmm_size_o(rmm_size_o),
    .rmm_we_o(rmm_we_o), .rmm_re_o(rmm_re_o), .rmm_data_i(rmm_data_i), .rmm_err_i(rmm_err_i),
    .rmm_idle_i(rmm_idle_i), .rmm_abort_o(rmm_abort_o)
  );

  assign rmm_idle_i = m_idle;
  assign rmm_data_i = rd_tab[(m_cur - f_base) & 7];
  assign rmm_err_i = (m_cur - f_base) == m_err_idx;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(posedge clk_i) begin
    if (rst_i) begin
      m_idle <= 1; m_dly <= 0;
    end else if (rmm_abort_o) begin
      m_idle <= 1; n_abort <= n_abort + 1; abort_cyc <= cyc;
    end else if (rmm_we_o || rmm_re_o) begin
      if (!m_idle) viol <= viol + 1;
      s_addr[scnt & 1023] <= rmm_addr_o; s_data[scnt & 1023] <= rmm_data_o;
      s_size[scnt & 1023] <= rmm_size_o; s_we[scnt & 1023] <= rmm_we_o; s_cyc[scnt & 1023] <= cyc;
      m_cur <= scnt; scnt <= scnt + 1; m_idle <= 0; m_dly <= m_delay;
    end else if (!m_idle) begin
      if (rmm_addr_o !== s_addr[(scnt - 1) & 1023] || rmm_data_o !== s_data[(scnt - 1) & 1023] ||
          rmm_size_o !== s_size[(scnt - 1) & 1023]) unstable <= unstable + 1;
      if (!m_hang) begin
        if (m_dly <= 1) m_idle <= 1;
        else m_dly <= m_dly - 1;
      end
    end
  end

  always @(posedge clk_i) if (tx_valid_o && tx_ready_i) begin
    tx_buf[tcnt & 1023] <= tx_data_o; tcnt <= tcnt + 1;
  end

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    rx_data_i = b; rx_valid_i = 1;
    while (!rx_ready_o && t < 5000) begin @(negedge clk_i); t++; end
    if (t >= 5000) begin n_chk++; n_fail++; $display("FAIL rx_accept: byte %h not accepted within %0d cycles", b, t); end
    @(negedge clk_i);
    rx_valid_i = 0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [31:0] a, input logic [7:0] cnt);
    send_byte(op);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    send_byte(cnt);
  endtask

  task automatic wait_tx(input int n, input int budget);
    int t = 0;
    while (tcnt < n && t < budget) begin @(negedge clk_i); t++; end
    if (tcnt < n) begin n_chk++; n_fail++; $display("FAIL tx_wait: got %0d bytes, need %0d", tcnt, n); end
  endtask

  task automatic test_reset;
    rst_i = 1;
    repeat (3) @(negedge clk_i);
    n_chk++; if (rx_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_rx_ready: got %b want 0", rx_ready_o); end
    n_chk++; if (tx_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid_o); end
    n_chk++; if ({rmm_we_o, rmm_re_o, rmm_abort_o} !== 3'b000) begin n_fail++; $display("FAIL reset_strobes: got %b want 000", {rmm_we_o, rmm_re_o, rmm_abort_o}); end
    n_chk++; if ({rmm_addr_o, rmm_data_o, rmm_size_o, tx_data_o} !== 74'd0) begin n_fail++; $display("FAIL reset_buses: addr %h data %h size %h tx %h want 0", rmm_addr_o, rmm_data_o, rmm_size_o, tx_data_o); end
    rst_i = 0;
    @(negedge clk_i);
    n_chk++; if (rx_ready_o !== 1'b1) begin n_fail++; $display("FAIL post_reset_rx_ready: got %b want 1", rx_ready_o); end
  endtask

  task automatic test_write_word;
    int b0 = scnt, t0 = tcnt;
    m_delay = 40; f_base = scnt;
    send_frame(8'h70, 32'h12345678, 8'h01);
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    wait_tx(t0 + 1, 2000);
    n_chk++; if (scnt - b0 !== 1) begin n_fail++; $display("FAIL ww_count: got %0d want 1", scnt - b0); end
    n_chk++; if (s_we[b0] !== 1'b1) begin n_fail++; $display("FAIL ww_we: got %b want 1", s_we[b0]); end
    n_chk++; if (s_addr[b0] !== 32'h12345678) begin n_fail++; $display("FAIL ww_addr: got %h want 12345678", s_addr[b0]); end
    n_chk++; if (s_size[b0] !== 2'd3) begin n_fail++; $display("FAIL ww_size: got %0d want 3", s_size[b0]); end
    n_chk++; if (s_data[b0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ww_data: got %h want deadbeef", s_data[b0]); end
    n_chk++; if (tx_buf[t0] !== 8'hA0) begin n_fail++; $display("FAIL ww_status: got %h want a0", tx_buf[t0]); end
  endtask

  task automatic test_block_read;
    int b0 = scnt, t0 = tcnt;
    logic [7:0] exp [0:8] = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h44, 8'h44, 8'hA0};
    m_delay = 5; f_base = scnt;
    rd_tab[0] = 32'h1111; rd_tab[1] = 32'h2222; rd_tab[2] = 32'h3333; rd_tab[3] = 32'h4444;
    send_frame(8'hA0, 32'h00001000, 8'h04);
    wait_tx(t0 + 9, 3000);
    n_chk++; if (scnt - b0 !== 4) begin n_fail++; $display("FAIL br_count: got %0d want 4", scnt - b0); end
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (s_addr[b0 + i] !== 32'h1000 + 32'(2 * i) || s_we[b0 + i] !== 1'b0)
        begin n_fail++; $display("FAIL br_strobe%0d: addr %h we %b want %h re", i, s_addr[b0 + i], s_we[b0 + i], 32'h1000 + 32'(2 * i)); end
    end
    for (int i = 0; i < 9; i++) begin
      n_chk++; if (tx_buf[t0 + i] !== exp[i]) begin n_fail++; $display("FAIL br_tx%0d: got %h want %h", i, tx_buf[t0 + i], exp[i]); end
    end
  endtask

  task automatic test_aud_err;
    int b0 = scnt, t0 = tcnt;
    m_delay = 5; f_base = scnt; m_err_idx = 1; rd_tab[0] = 32'h1111;
    send_frame(8'hA0, 32'h00002000, 8'h03);
    wait_tx(t0 + 3, 3000);
    repeat (200) @(negedge clk_i);
    n_chk++; if (scnt - b0 !== 2) begin n_fail++; $display("FAIL ae_count: got %0d want 2", scnt - b0); end
    n_chk++; if (tcnt - t0 !== 3) begin n_fail++; $display("FAIL ae_tx_len: got %0d want 3", tcnt - t0); end
    n_chk++; if ({tx_buf[t0], tx_buf[t0 + 1], tx_buf[t0 + 2]} !== 24'h1111A2) begin n_fail++; $display("FAIL ae_tx: got %h%h%h want 1111a2", tx_buf[t0], tx_buf[t0 + 1], tx_buf[t0 + 2]); end
    m_err_idx = -1;
  endtask

  task automatic test_timeout;
    int b0 = scnt, t0 = tcnt, a0 = n_abort;
    m_delay = 3; m_hang = 1; f_base = scnt;
    send_frame(8'h80, 32'h00003000, 8'h01);
    wait_tx(t0 + 1, 500);
    m_hang = 0;
    n_chk++; if (tx_buf[t0] !== 8'hA4) begin n_fail++; $display("FAIL to_status: got %h want a4", tx_buf[t0]); end
    n_chk++; if (n_abort - a0 !== 1) begin n_fail++; $display("FAIL to_abort_count: got %0d want 1", n_abort - a0); end
    n_chk++; if (abort_cyc - s_cyc[b0] !== 64) begin n_fail++; $display("FAIL to_latency: got %0d want 64", abort_cyc - s_cyc[b0]); end
    f_base = scnt;
    send_frame(8'h40, 32'h00003004, 8'h01);
    send_byte(8'h77);
    wait_tx(t0 + 2, 500);
    n_chk++; if (tx_buf[t0 + 1] !== 8'hA0) begin n_fail++; $display("FAIL to_next_status: got %h want a0", tx_buf[t0 + 1]); end
    n_chk++; if (s_data[b0 + 1] !== 32'h77 || s_addr[b0 + 1] !== 32'h3004) begin n_fail++; $display("FAIL to_next_strobe: data %h addr %h want 77 3004", s_data[b0 + 1], s_addr[b0 + 1]); end
  endtask

  task automatic test_reset_midframe;
    int b0 = scnt, t0 = tcnt;
    send_byte(8'h70); send_byte(8'h78); send_byte(8'h56);
    rst_i = 1;
    repeat (2) @(negedge clk_i);
    rst_i = 0;
    repeat (50) @(negedge clk_i);
    n_chk++; if (tcnt !== t0 || scnt !== b0) begin n_fail++; $display("FAIL rst_mid_quiet: tx %0d strobes %0d want 0 0", tcnt - t0, scnt - b0); end
    n_chk++; if (rx_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b want 1", rx_ready_o); end
  endtask

  task automatic test_bad_op;
    int b0 = scnt, t0 = tcnt;
    send_byte(8'hC0);
    wait_tx(t0 + 1, 200);
    n_chk++; if (tx_buf[t0] !== 8'hE1) begin n_fail++; $display("FAIL bo_status: got %h want e1", tx_buf[t0]); end
    send_frame(8'h40, 32'h00000010, 8'h01);
    send_byte(8'h5A);
    wait_tx(t0 + 2, 500);
    n_chk++; if (tx_buf[t0 + 1] !== 8'hA0) begin n_fail++; $display("FAIL bo_next_status: got %h want a0", tx_buf[t0 + 1]); end
    n_chk++; if (scnt - b0 !== 1 || s_we[b0] !== 1'b1 || s_addr[b0] !== 32'h10 || s_data[b0] !== 32'h5A || s_size[b0] !== 2'd0)
      begin n_fail++; $display("FAIL bo_strobe: n %0d we %b addr %h data %h size %0d want 1 1 10 5a 0", scnt - b0, s_we[b0], s_addr[b0], s_data[b0], s_size[b0]); end
  endtask

  task automatic test_backpressure;
    int b0 = scnt, t0 = tcnt, t = 0, bad = 0, sc;
    logic [7:0] d0;
    logic [7:0] exp [0:8] = '{8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01, 8'hA0};
    m_delay = 3; f_base = scnt; tx_ready_i = 0;
    rd_tab[0] = 32'h89ABCDEF; rd_tab[1] = 32'h01234567;
    send_frame(8'hB0, 32'h00004000, 8'h02);
    while (!tx_valid_o && t < 500) begin @(negedge clk_i); t++; end
    d0 = tx_data_o; sc = scnt;
    repeat (100) begin @(negedge clk_i); if (!tx_valid_o || tx_data_o !== d0) bad++; end
    n_chk++; if (d0 !== 8'hEF) begin n_fail++; $display("FAIL bp_first: got %h want ef", d0); end
    n_chk++; if (bad !== 0) begin n_fail++; $display("FAIL bp_stable: %0d unstable cycles want 0", bad); end
    n_chk++; if (scnt - sc !== 0 || sc - b0 !== 1) begin n_fail++; $display("FAIL bp_no_strobe: %0d during stall, %0d before, want 0 1", scnt - sc, sc - b0); end
    tx_ready_i = 1;
    wait_tx(t0 + 9, 1000);
    for (int i = 0; i < 9; i++) begin
      n_chk++; if (tx_buf[t0 + i] !== exp[i]) begin n_fail++; $display("FAIL bp_tx%0d: got %h want %h", i, tx_buf[t0 + i], exp[i]); end
    end
  endtask

  task automatic test_cnt0_wrap;
    int b0 = scnt, t0 = tcnt;
    m_delay = 2; f_base = scnt;
    send_frame(8'h40, 32'hFFFFFF80, 8'h00);
    for (int i = 0; i < 256; i++) send_byte(8'(i));
    wait_tx(t0 + 1, 2000);
    n_chk++; if (scnt - b0 !== 256) begin n_fail++; $display("FAIL c0_count: got %0d want 256", scnt - b0); end
    n_chk++; if (s_addr[b0 + 127] !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL c0_addr127: got %h want ffffffff", s_addr[b0 + 127]); end
    n_chk++; if (s_addr[b0 + 128] !== 32'h0) begin n_fail++; $display("FAIL c0_addr128: got %h want 0", s_addr[b0 + 128]); end
    n_chk++; if (s_addr[b0 + 255] !== 32'h7F) begin n_fail++; $display("FAIL c0_addr255: got %h want 7f", s_addr[b0 + 255]); end
    n_chk++; if (s_data[b0 + 200] !== 32'hC8 || s_size[b0 + 5] !== 2'd0) begin n_fail++; $display("FAIL c0_data: data %h size %0d want c8 0", s_data[b0 + 200], s_size[b0 + 5]); end
    n_chk++; if (tx_buf[t0] !== 8'hA0) begin n_fail++; $display("FAIL c0_status: got %h want a0", tx_buf[t0]); end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rd_tab[i] = 0;
    test_reset;
    test_write_word;
    test_block_read;
    test_aud_err;
    test_timeout;
    test_reset_midframe;
    test_bad_op;
    test_backpressure;
    test_cnt0_wrap;
    n_chk++; if (viol !== 0) begin n_fail++; $display("FAIL strobe_busy: %0d strobes while busy want 0", viol); end
    n_chk++; if (unstable !== 0) begin n_fail++; $display("FAIL bus_stable: %0d changes while busy want 0", unstable); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
